// File: rtl/fetch_pc_gen.sv
// IF-stage fetch PC generator: drives the BTB lookup and I-mem request, captures
// the fetched instruction with its branch prediction and hands it to decode.
module fetch_pc_gen #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] btb_pc,
    input  logic        btb_hit,
    input  logic        btb_taken,
    input  logic [15:0] btb_target,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_pc,
    output logic [15:0] if_npc,
    output logic [15:0] if_instr,
    output logic        if_pred_taken,
    output logic [15:0] if_pred_target
);

    localparam int unsigned PC_W = 16;
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(16'hFFFE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] redir_q, redir_d;
    logic            capture;
    logic            pred;
    logic [PC_W-1:0] pc_inc;

    assign pred   = btb_hit & btb_taken;
    assign pc_inc = pc_q + PC_W'(2);

    // Next-state and PC selection; redirect outranks every other event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = redirect_pc & ALIGN_MASK;
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    if (imem_resp) begin
                        pc_d    = redirect_pc & ALIGN_MASK;
                        state_d = FETCH;
                    end else begin
                        redir_d = redirect_pc & ALIGN_MASK;
                        state_d = FLUSH;
                    end
                end else if (imem_resp) begin
                    capture = 1'b1;
                    pc_d    = (pred ? btb_target : pc_inc) & ALIGN_MASK;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc & ALIGN_MASK;
                    state_d = FETCH;
                end else if (if_ready) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (imem_resp) begin
                    pc_d    = (redirect_valid ? redirect_pc : redir_q) & ALIGN_MASK;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    redir_d = redirect_pc & ALIGN_MASK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC & ALIGN_MASK;
            redir_q   <= '0;
            imem_read <= 1'b0;
            if_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            imem_read <= (state_d == FETCH) || (state_d == FLUSH);
            if_valid  <= (state_d == HOLD);
        end
    end

    // Packet payload, loaded only on an accepted (non-redirected) fetch response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc          <= '0;
            if_npc         <= '0;
            if_instr       <= '0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= '0;
        end else if (capture) begin
            if_pc          <= pc_q;
            if_npc         <= pc_inc;
            if_instr       <= imem_rdata;
            if_pred_taken  <= pred;
            if_pred_target <= pred ? btb_target : '0;
        end
    end

    assign btb_pc       = pc_q;
    assign imem_address = pc_q;

endmodule
